// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between two byte requesters, round-robin with per-requester lock.
// Latency: txbegin in the 2nd cycle after a request is seen idle; ack in the cycle after txbusy is first seen low.
// Backpressure: requests wait in IDLE while txbusy is high; req must be held until ack.
// Ports: req/data/lock in, ack out (per requester); txdata/txbegin out, txbusy in (to uart_tx);
//        grant out (one-hot owner, 00 when free); err out (start timeout, pulses with ack).
module uart_tx_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       lock0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       lock1,
  output logic       ack1,
  output logic [7:0] txdata,
  output logic       txbegin,
  input  logic       txbusy,
  output logic [1:0] grant,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAITBUSY, SENDING, DONE} state_t;

  state_t     state;
  logic       rr;        // last serviced requester; the other one wins a tie
  logic [7:0] cnt;       // cycles left for txbusy to rise after txbegin

  logic owner;
  logic own_req;
  logic own_lock;
  logic win_sel;
  logic win_vld;

  // Owner is only meaningful while grant is non-zero; grant[1] selects requester 1.
  always_comb begin
    owner    = grant[1];
    own_req  = owner ? req1 : req0;
    own_lock = owner ? lock1 : lock0;
    win_sel  = 1'b0;
    win_vld  = 1'b0;
    if (grant != 2'b00) begin
      // Locked: nobody but the owner can be launched.
      win_sel = owner;
      win_vld = own_req && !txbusy;
    end else begin
      win_sel = (req0 && req1) ? ~rr : req1;
      win_vld = (req0 || req1) && !txbusy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      txbegin <= 1'b0;
      txdata  <= 8'h00;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      grant   <= 2'b00;
      rr      <= 1'b1;
      cnt     <= 8'd0;
    end else begin
      // Pulses default low; each is raised only on entry to the state that owns it.
      txbegin <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant   <= win_sel ? 2'b10 : 2'b01;
            txdata  <= win_sel ? data1 : data0;
            txbegin <= 1'b1;
            cnt     <= 8'(TIMEOUT);
            state   <= LAUNCH;
          end else if (grant != 2'b00 && !own_req && !own_lock) begin
            // Owner gave up its lock without another byte: free the grant,
            // arbitration resumes in the next IDLE cycle.
            grant <= 2'b00;
            rr    <= owner;
          end
        end
        LAUNCH: begin
          state <= WAITBUSY;
        end
        WAITBUSY: begin
          if (txbusy) begin
            state <= SENDING;
          end else if (cnt <= 8'd1) begin
            cnt   <= 8'd0;
            ack0  <= !owner;
            ack1  <= owner;
            err   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SENDING: begin
          // Frame length belongs to uart_tx, so no timeout here.
          if (!txbusy) begin
            ack0  <= !owner;
            ack1  <= owner;
            state <= DONE;
          end
        end
        DONE: begin
          // Lock is sampled here, before the requester updates it on this edge.
          if (!own_lock) begin
            grant <= 2'b00;
            rr    <= owner;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a behavioural uart_tx (PERIOD=8).
// Inputs are driven 1 time unit after posedge; outputs are sampled 1 time unit after negedge.
// The uart_tx model decodes its own tx line so transmitted bytes are checked from the serial stream.
module tb_uart_tx_arbiter;
  localparam int PERIOD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0, lock0, ack0, req1, lock1, ack1;
  logic [7:0] data0, data1, txdata;
  logic       txbegin, txbusy, err;
  logic [1:0] grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .lock0(lock0), .ack0(ack0),
    .req1(req1), .data1(data1), .lock1(lock1), .ack1(ack1),
    .txdata(txdata), .txbegin(txbegin), .txbusy(txbusy),
    .grant(grant), .err(err)
  );

  // ---------------- uart_tx model ----------------
  logic       model_en = 1'b1;
  logic       busy_force = 1'b0;
  logic       mdl_busy = 1'b0;
  logic       tx_line = 1'b1;
  logic [7:0] mdl_sh = 8'h00;
  logic [7:0] rx_sh = 8'h00;
  int         mdl_cnt = 0;
  int         mdl_bit = 0;
  logic [7:0] rx_q[$];

  assign txbusy = model_en ? mdl_busy : busy_force;

  always @(posedge clk) begin
    if (!mdl_busy) begin
      tx_line <= 1'b1;
      if (model_en && txbegin) begin
        mdl_busy <= 1'b1;
        mdl_sh   <= txdata;
        mdl_cnt  <= 0;
        mdl_bit  <= 0;
        tx_line  <= 1'b0;
      end
    end else begin
      if (mdl_cnt == PERIOD / 2 && mdl_bit >= 1 && mdl_bit <= 8)
        rx_sh <= {tx_line, rx_sh[7:1]};
      if (mdl_cnt == PERIOD - 1) begin
        mdl_cnt <= 0;
        if (mdl_bit == 9) begin
          mdl_busy <= 1'b0;
          tx_line  <= 1'b1;
          rx_q.push_back(rx_sh);
        end else begin
          mdl_bit <= mdl_bit + 1;
          tx_line <= (mdl_bit == 8) ? 1'b1 : mdl_sh[mdl_bit[2:0]];
        end
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle bookkeeping at negedge; main thread reads it 1 unit later.
  int         cyc = 0;
  int         last_busy_cyc = 0;
  int         n_begin = 0;
  int         n_err = 0;
  logic [7:0] last_begin_dat = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (txbusy) last_busy_cyc = cyc;
    if (txbegin) begin
      n_begin++;
      last_begin_dat = txdata;
    end
    if (err) n_err++;
    chk("inv_ack_exclusive", {31'b0, ack0 && ack1}, 32'd0);
    chk("inv_grant_onehot", {31'b0, grant == 2'b11}, 32'd0);
  end

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      smp();
      if (ack0 || ack1) ok = 1'b1;
    end
  endtask

  task automatic wait_begin(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      smp();
      if (txbegin) ok = 1'b1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txbegin"}, {31'b0, txbegin}, 32'd0);
    chk({tag, "_txdata"}, {24'b0, txdata}, 32'h00);
    chk({tag, "_ack0"}, {31'b0, ack0}, 32'd0);
    chk({tag, "_ack1"}, {31'b0, ack1}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_grant"}, {30'b0, grant}, 32'd0);
  endtask

  task automatic chk_rx(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] v;
    v = 'x;
    if (idx < rx_q.size()) v = {24'b0, rx_q[idx]};
    chk(tag, v, {24'b0, exp});
  endtask

  task automatic do_reset();
    drv();
    rst_n = 1'b0;
    #1;
    chk_reset("rst");
    drv();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic       ok;
    int         nb, ne;
    logic [7:0] pkt [3];

    req0 = 0; req1 = 0; data0 = 0; data1 = 0; lock0 = 0; lock1 = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset("init");
    repeat (3) drv();
    rst_n = 1'b1;

    // Single byte 0x55 through the model.
    rx_q.delete();
    nb = n_begin;
    req0 = 1; data0 = 8'h55;
    wait_ack(300, ok);
    chk("t1_ack_seen", {31'b0, ok}, 32'd1);
    chk("t1_ack0", {31'b0, ack0}, 32'd1);
    chk("t1_ack1", {31'b0, ack1}, 32'd0);
    chk("t1_err", {31'b0, err}, 32'd0);
    chk("t1_one_txbegin", n_begin - nb, 32'd1);
    chk("t1_txdata", {24'b0, last_begin_dat}, 32'h55);
    // ack appears two samples after the last sample with txbusy high
    chk("t1_ack_latency", cyc - last_busy_cyc, 32'd2);
    drv();
    req0 = 0;
    smp();
    chk("t1_ack_one_cycle", {31'b0, ack0}, 32'd0);
    chk("t1_grant_released", {30'b0, grant}, 32'd0);
    chk("t1_rx_count", rx_q.size(), 32'd1);
    chk_rx("t1_rx_byte", 0, 8'h55);

    // Both requesting, no lock: strict alternation starting with requester 0.
    do_reset();
    rx_q.delete();
    req0 = 1; data0 = 8'hA1; req1 = 1; data1 = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      wait_ack(400, ok);
      chk($sformatf("t2_ack_seen_%0d", i), {31'b0, ok}, 32'd1);
      chk($sformatf("t2_ack_order_%0d", i), {30'b0, ack1, ack0}, (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    drv();
    req0 = 0; req1 = 0;
    chk("t2_rx_count", rx_q.size(), 32'd4);
    chk_rx("t2_rx0", 0, 8'hA1);
    chk_rx("t2_rx1", 1, 8'hB2);
    chk_rx("t2_rx2", 2, 8'hA1);
    chk_rx("t2_rx3", 3, 8'hB2);

    // Locked packet 10,11,12 from requester 0 while requester 1 waits.
    do_reset();
    rx_q.delete();
    pkt = '{8'h10, 8'h11, 8'h12};
    req0 = 1; lock0 = 1; data0 = pkt[0]; req1 = 1; data1 = 8'hB2;
    for (int i = 0; i < 3; i++) begin
      wait_ack(300, ok);
      chk($sformatf("t3_ack_seen_%0d", i), {31'b0, ok}, 32'd1);
      chk($sformatf("t3_ack0_%0d", i), {30'b0, ack1, ack0}, 32'd1);
      chk($sformatf("t3_grant_%0d", i), {30'b0, grant}, 32'd1);
      drv();
      if (i < 2) begin
        data0 = pkt[i + 1];
        lock0 = (i < 1);
      end else begin
        req0 = 0;
      end
    end
    wait_ack(300, ok);
    chk("t3_ack_seen_b2", {31'b0, ok}, 32'd1);
    chk("t3_ack1_b2", {30'b0, ack1, ack0}, 32'd2);
    chk("t3_grant_b2", {30'b0, grant}, 32'd2);
    drv();
    req1 = 0;
    chk("t3_rx_count", rx_q.size(), 32'd4);
    chk_rx("t3_rx0", 0, 8'h10);
    chk_rx("t3_rx1", 1, 8'h11);
    chk_rx("t3_rx2", 2, 8'h12);
    chk_rx("t3_rx3", 3, 8'hB2);

    // Start timeout: txbusy tied low.
    do_reset();
    model_en = 0; busy_force = 0;
    nb = n_begin;
    req1 = 1; data1 = 8'h3C;
    wait_begin(10, ok);
    chk("t4_launch_seen", {31'b0, ok}, 32'd1);
    // txbegin sample is decision+1; ack/err expected at decision+6
    repeat (4) smp();
    chk("t4_early_ack1", {31'b0, ack1}, 32'd0);
    chk("t4_early_err", {31'b0, err}, 32'd0);
    smp();
    chk("t4_ack1", {31'b0, ack1}, 32'd1);
    chk("t4_err", {31'b0, err}, 32'd1);
    chk("t4_ack0", {31'b0, ack0}, 32'd0);
    drv();
    req1 = 0;
    smp();
    chk("t4_err_pulse", {31'b0, err}, 32'd0);
    chk("t4_grant_released", {30'b0, grant}, 32'd0);
    repeat (20) smp();
    chk("t4_no_relaunch", n_begin - nb, 32'd1);
    chk("t4_txdata_held", {24'b0, txdata}, 32'h3C);

    // Reset during the data bits of a frame.
    do_reset();
    model_en = 1;
    rx_q.delete();
    req0 = 1; data0 = 8'h96;
    wait_begin(10, ok);
    chk("t5_launch_seen", {31'b0, ok}, 32'd1);
    repeat (30) smp();
    chk("t5_mid_frame_busy", {31'b0, txbusy}, 32'd1);
    rst_n = 0; req0 = 0;
    #1 chk_reset("t5_async");
    drv();
    rst_n = 1; req0 = 1; data0 = 8'h5A;
    wait_begin(200, ok);
    chk("t5_relaunch_seen", {31'b0, ok}, 32'd1);
    chk("t5_launch_after_idle", cyc - last_busy_cyc, 32'd2);
    chk("t5_txdata", {24'b0, txdata}, 32'h5A);
    wait_ack(300, ok);
    chk("t5_ack0", {30'b0, ack1, ack0}, 32'd1);
    drv();
    req0 = 0;
    chk("t5_rx_count", rx_q.size(), 32'd2);
    chk_rx("t5_rx_new", 1, 8'h5A);

    // txbusy already high when the request arrives.
    do_reset();
    model_en = 0; busy_force = 1;
    rx_q.delete();
    nb = n_begin; ne = n_err;
    req0 = 1; data0 = 8'hC3;
    repeat (20) smp();
    chk("t6_no_begin_while_busy", n_begin - nb, 32'd0);
    chk("t6_no_err_while_busy", n_err - ne, 32'd0);
    drv();
    busy_force = 0; model_en = 1;
    smp();
    chk("t6_not_yet", {31'b0, txbegin}, 32'd0);
    smp();
    chk("t6_launch", {31'b0, txbegin}, 32'd1);
    chk("t6_txdata", {24'b0, txdata}, 32'hC3);
    wait_ack(300, ok);
    chk("t6_ack0", {30'b0, ack1, ack0}, 32'd1);
    chk("t6_err", {31'b0, err}, 32'd0);
    drv();
    req0 = 0;
    chk_rx("t6_rx", 0, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
